// File: rtl/decoder_2_to_4_seq_pkg.sv
// Shared types for the sequenced 2-to-4 decoder: FSM state encoding and
// the one-entry input buffer layout.
package decoder_2_to_4_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic       full;
        logic [1:0] code;
    } code_buf_t;

endpackage

// File: rtl/decoder_2_to_4_seq_decode.sv
// Combinational 2-to-4 one-hot decoder with an active-high enable.
module decode_2_to_4 (
    input  logic A,
    input  logic B,
    input  logic en,
    output logic Y0,
    output logic Y1,
    output logic Y2,
    output logic Y3
);

    assign Y0 = en && !A && !B;
    assign Y1 = en && !A &&  B;
    assign Y2 = en &&  A && !B;
    assign Y3 = en &&  A &&  B;

endmodule

// File: rtl/decoder_2_to_4_seq.sv
// Sequenced 2-to-4 decoder: buffers one (A,B) code and stretches it into a
// HOLD_CYCLES-wide one-hot pulse followed by GAP_CYCLES of all-zero output.
module decoder_2_to_4_seq
    import decoder_2_to_4_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic A,
    input  logic B,
    input  logic en,
    output logic Y0,
    output logic Y1,
    output logic Y2,
    output logic Y3,
    output logic busy
);

    localparam int              CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > CNT_MAX) begin : g_bad_hold
        $error("decoder_2_to_4_seq: HOLD_CYCLES out of range");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > CNT_MAX) begin : g_bad_gap
        $error("decoder_2_to_4_seq: GAP_CYCLES out of range");
    end

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       active_code;
    code_buf_t        cbuf;
    logic             push;
    logic             pop;
    logic             cnt_done;

    assign cnt_done = (cnt == '0);
    assign push     = in_valid && !cbuf.full;
    // A pop needs a full buffer and a push an empty one, so they never coincide.
    assign pop      = en && cbuf.full &&
                      (state == IDLE ||
                       (cnt_done && (state == GAP || (state == HOLD && GAP_CYCLES == 0))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            active_code <= '0;
            cbuf        <= '0;
        end else begin
            if (pop) begin
                cbuf.full <= 1'b0;
            end else if (push) begin
                cbuf.full <= 1'b1;
                cbuf.code <= {A, B};
            end

            if (pop) begin
                active_code <= cbuf.code;
                cnt         <= HOLD_LD;
                state       <= HOLD;
            end else if (en) begin
                case (state)
                    IDLE: ;
                    HOLD: begin
                        if (!cnt_done) begin
                            cnt <= cnt - 1'b1;
                        end else if (GAP_CYCLES > 0) begin
                            cnt   <= GAP_LD;
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    GAP: begin
                        if (!cnt_done) cnt <= cnt - 1'b1;
                        else           state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign in_ready = !cbuf.full;
    assign busy     = (state != IDLE) || cbuf.full;

    decode_2_to_4 u_decode (
        .A  (active_code[1]),
        .B  (active_code[0]),
        .en (en && (state == HOLD)),
        .Y0 (Y0),
        .Y1 (Y1),
        .Y2 (Y2),
        .Y3 (Y3)
    );

endmodule

// File: tb/tb_decoder_2_to_4_seq.sv
// Bench for decoder_2_to_4_seq: two instances (with and without a gap),
// a job-based reference model, directed timing pins and random traffic.
module tb_decoder_2_to_4_seq;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             en    = 1'b0;
    logic [1:0]       v     = '0;
    logic [1:0][1:0]  c     = '0;
    wire  [1:0][3:0]  yv;
    wire  [1:0]       rdy;
    wire  [1:0]       bsy;

    int nchk = 0;
    int nerr = 0;

    int hc [2] = '{4, 4};
    int gc [2] = '{1, 0};

    always #5 clk = ~clk;

    decoder_2_to_4_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) u_dut_gap (
        .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_ready(rdy[0]),
        .A(c[0][1]), .B(c[0][0]), .en(en),
        .Y0(yv[0][0]), .Y1(yv[0][1]), .Y2(yv[0][2]), .Y3(yv[0][3]), .busy(bsy[0])
    );

    decoder_2_to_4_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CNT_W(8)) u_dut_nogap (
        .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_ready(rdy[1]),
        .A(c[1][1]), .B(c[1][0]), .en(en),
        .Y0(yv[1][0]), .Y1(yv[1][1]), .Y2(yv[1][2]), .Y3(yv[1][3]), .busy(bsy[1])
    );

    // Reference model: a one-slot queue plus a current job with remaining
    // hold and gap cycle counts.
    bit       mbuf  [2];
    bit [1:0] mbc   [2];
    bit       mact  [2];
    bit [1:0] mcode [2];
    int       rh    [2];
    int       rg    [2];
    bit       acc   [2];
    bit       was_full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mbuf[i] = 0; mact[i] = 0; rh[i] = 0; rg[i] = 0; acc[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                was_full = mbuf[i];
                acc[i]   = 0;
                if (en) begin
                    if (mact[i]) begin
                        if (rh[i] > 0) rh[i]--;
                        else           rg[i]--;
                        if (rh[i] == 0 && rg[i] == 0) mact[i] = 0;
                    end
                    if (!mact[i] && was_full) begin
                        mact[i]  = 1;
                        mcode[i] = mbc[i];
                        rh[i]    = hc[i];
                        rg[i]    = gc[i];
                        mbuf[i]  = 0;
                    end
                end
                if (v[i] && !was_full) begin
                    mbuf[i] = 1;
                    mbc[i]  = c[i];
                    acc[i]  = 1;
                end
            end
        end
    end

    function automatic logic [3:0] exp_y(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return (en && mact[i] && rh[i] > 0) ? (one << mcode[i]) : 4'b0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("y[%0d]", i), 32'(yv[i]), 32'(exp_y(i)));
                chk($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'(!mbuf[i]));
                chk($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(mact[i] || mbuf[i]));
                chk($sformatf("onehot[%0d]", i), 32'($countones(yv[i]) <= 1), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Feed up to four codes into one instance (each held until accepted) and
    // record outputs on the negedge after each edge e0..e(nk-1).
    task automatic seq(input int idx, input int n, input logic [3:0][1:0] codes, input int nk,
                       output logic [3:0][31:0] yh, output logic [31:0] rdh,
                       output logic [31:0] bh);
        int sent;
        sent = 0;
        yh   = '0;
        rdh  = '0;
        bh   = '0;
        v[idx] = 1'b1;
        c[idx] = codes[0];
        tick();
        for (int k = 0; k < nk; k++) begin
            if (acc[idx]) begin
                sent++;
                if (sent < n) c[idx] = codes[sent];
                else          v[idx] = 1'b0;
            end
            @(negedge clk);
            for (int j = 0; j < 4; j++) yh[j][k] = yv[idx][j];
            rdh[k] = rdy[idx];
            bh[k]  = bsy[idx];
            tick();
        end
    endtask

    logic [3:0][31:0] yh;
    logic [31:0]      rdh, bh;
    logic [3:0][1:0]  codes;
    logic [12:0]      frz;

    initial begin
        #1 rst_n = 1'b0;
        #3;
        chk("rst_y", 32'(yv), 32'd0);
        chk("rst_ready", 32'(rdy), 32'h3);
        chk("rst_busy", 32'(bsy), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(rdy), 32'h3);
        chk("idle_busy", 32'(bsy), 32'd0);
        tick();

        // Single code 10 with the default gap.
        codes = {2'b00, 2'b00, 2'b00, 2'b10};
        seq(0, 1, codes, 10, yh, rdh, bh);
        chk("single_y2", yh[2][7:0], 32'h1E);
        chk("single_busy", bh[7:0], 32'h3F);
        repeat (3) tick();

        // Back-to-back 01 then 11 with no gap.
        codes = {2'b00, 2'b00, 2'b11, 2'b01};
        seq(1, 2, codes, 11, yh, rdh, bh);
        chk("b2b_y1", yh[1][10:0], 32'h01E);
        chk("b2b_y3", yh[3][10:0], 32'h1E0);
        chk("b2b_ready", rdh[10:0], 32'h7E2);
        repeat (3) tick();

        // Backpressure: 00 waits behind a full buffer.
        codes = {2'b00, 2'b00, 2'b01, 2'b10};
        seq(0, 3, codes, 18, yh, rdh, bh);
        chk("bp_y2", yh[2][17:0], 32'h0001E);
        chk("bp_y1", yh[1][17:0], 32'h003C0);
        chk("bp_y0", yh[0][17:0], 32'h07800);
        repeat (3) tick();

        // Enable freeze for three cycles mid-hold of code 10.
        v[0] = 1'b1;
        c[0] = 2'b10;
        tick();
        frz = '0;
        for (int k = 0; k < 13; k++) begin
            if (acc[0]) v[0] = 1'b0;
            if (k == 3) en = 1'b0;
            if (k == 6) en = 1'b1;
            @(negedge clk);
            frz[k] = yv[0][2];
            tick();
        end
        chk("freeze_y2", 32'(frz), 32'h0C6);
        chk("freeze_cnt", 32'($countones(frz)), 32'd4);
        repeat (3) tick();

        // All four codes in turn.
        codes = {2'b11, 2'b10, 2'b01, 2'b00};
        seq(0, 4, codes, 26, yh, rdh, bh);
        for (int j = 0; j < 4; j++) chk($sformatf("exh_y%0d", j), 32'($countones(yh[j])), 32'd4);
        chk("exh_y3_pos", yh[3][25:0], 32'h000F0000);
        repeat (3) tick();

        // Asynchronous reset in the middle of a hold.
        v[0] = 1'b1;
        c[0] = 2'b11;
        tick();
        v[0] = 1'b0;
        tick();
        tick();
        #1;
        chk("pre_rst_y3", 32'(yv[0]), 32'h8);
        rst_n = 1'b0;
        #1;
        chk("async_rst_y", 32'(yv), 32'd0);
        chk("async_rst_ready", 32'(rdy), 32'h3);
        chk("async_rst_busy", 32'(bsy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic with protocol-respecting sources.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i] || acc[i]) begin
                    v[i] = ($urandom_range(0, 99) < 60);
                    c[i] = 2'($urandom);
                end
            end
            en = ($urandom_range(0, 99) < 85);
            tick();
        end
        v  = '0;
        en = 1'b1;
        repeat (20) tick();
        chk("drain_busy", 32'(bsy), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/decoder_2_to_4_seq.md
Name: decoder_2_to_4_seq

Overview:
- Sequenced 2-to-4 decoder: the inverse of the 4-to-2 encoder's (A,B) code.
- Accepts a 2-bit code (A = MSB, B = LSB) over a valid/ready handshake, buffers one code, and drives the matching one-hot line Y0..Y3 for a fixed number of cycles, followed by an optional idle gap.
- Drives select lines or LEDs downstream of an encoder so that back-to-back codes appear as distinct, stretched pulses.

Parameters:
- HOLD_CYCLES, 4, cycles each one-hot output stays high; legal range 1..2^CNT_W-1.
- GAP_CYCLES, 1, all-zero cycles inserted after each hold; legal range 0..2^CNT_W-1.
- CNT_W, 8, width of the shared down-counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  code on A,B is valid
- in_ready  output  1  block can accept a code this cycle
- A  input  1  code MSB
- B  input  1  code LSB
- en  input  1  run enable; low freezes sequencing and blanks outputs
- Y0  output  1  high when active code = 00 and phase = HOLD
- Y1  output  1  high when active code = 01 and phase = HOLD
- Y2  output  1  high when active code = 10 and phase = HOLD
- Y3  output  1  high when active code = 11 and phase = HOLD
- busy  output  1  FSM not IDLE or buffer full

Behaviour:
- Clock, reset and decided interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset state: FSM = IDLE, buffer empty, counter = 0, Y0..Y3 = 0, busy = 0, in_ready = 1.
- Reset asserted mid-operation clears all state and outputs immediately, without waiting for a clock edge. Any buffered code is discarded.
- Input buffer: one entry (code plus full flag).
  - in_ready = !buf_full, taken directly from the register with no combinational path from in_valid.
  - Accept occurs on an edge where in_valid && in_ready.
  - A and B are sampled only on accept.
  - A code offered while in_ready = 0 is not taken; the source must hold it.
- FSM states: IDLE, HOLD, GAP. Counter loads on entry to each state.
  - IDLE: if en && buf_full, then at the next edge: active_code <= buffered code, buffer pops, cnt <= HOLD_CYCLES-1, go to HOLD.
  - HOLD: outputs Y[active_code] = 1. Each enabled edge, cnt decrements. On an edge with cnt == 0:
    - if GAP_CYCLES > 0: cnt <= GAP_CYCLES-1, go to GAP;
    - else if buf_full: load the next code directly into HOLD (no zero cycle between codes);
    - else: go to IDLE.
  - GAP: all Y outputs = 0. Each enabled edge, cnt decrements. On an edge with cnt == 0:
    - if buf_full: load the next code, go to HOLD;
    - else: go to IDLE.
- Outputs: Y registered-state decode, i.e. combinational from the state and active_code registers only, then gated by en. Exactly one Y line is high in HOLD; none are high otherwise.
- Latency: a code accepted on edge t while IDLE with en = 1 drives its Y line high from edge t+1 through edge t+1+HOLD_CYCLES.
- Simultaneous pop and push: a pop on edge t frees the buffer, so in_ready = 1 from edge t onward. There is no push on the same edge as a pop, since in_ready was 0 during that cycle.
- en = 0:
  - FSM, counter and active_code freeze.
  - All Y outputs read 0.
  - The buffer still accepts a code while empty.
  - On en returning to 1, operation resumes with the remaining count.
- Width rule: the counter is CNT_W bits. Parameter values outside the legal range are illegal and checked by an elaboration-time assertion.

Decomposition:
- Shared package (defines header): FSM state encodings IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2.
- One natural sub-module: decode_2_to_4. Purely combinational: inputs A, B, en; outputs Y0..Y3 one-hot. Instantiated on active_code with en = (state == HOLD) && en.

Test Plan:
- Reset: rst_n = 0, then release → Y0..Y3 = 0, in_ready = 1, busy = 0. Assert rst_n = 0 mid-HOLD → Y clears with no clock edge.
- Single code: defaults, send A=1, B=0 at edge t → Y2 high for edges t+1..t+5 (4 cycles), 1 zero cycle, then IDLE; busy drops after the GAP cycle.
- Back-to-back: GAP_CYCLES=0, send 01 then 11 with in_valid held high → Y1 high for 4 cycles, Y3 high for the next 4 with no zero cycle between. in_ready is low from the second accept until the first pop.
- Backpressure: buffer full and in HOLD, offer 00 → not accepted (in_ready = 0); accepted on the edge after the pop; Y0 appears after the current hold and gap.
- Enable freeze: drop en for 3 cycles mid-HOLD of code 10 → Y2 = 0 during the freeze; total Y2-high cycles remain 4.
- Exhaustive codes: send 00, 01, 10, 11 → exactly one of Y0, Y1, Y2, Y3 high respectively; never two lines high in any cycle (checked by assertion).
